// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with iterative shifts/rotate and optional
// shift-add MUL (enable with `define ALU_MUL_EN). Ports:
//   clk, rst_n        clock, async active-low reset
//   start, busy, done request / in-progress / one-cycle result pulse
//   opcode, arg1,
//   arg2, in_flg      operation, operands, incoming {Z,CY,S,P,OV}
//   res, res_hi,
//   out_flg           result, MUL high half, outgoing {Z,CY,S,P,OV}
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] arg1,
  input  logic [WIDTH-1:0] arg2,
  input  logic [4:0]       in_flg,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_hi,
  output logic [4:0]       out_flg
);

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpAnd = 4'd2;
  localparam logic [3:0] OpOr  = 4'd3;
  localparam logic [3:0] OpXor = 4'd4;
  localparam logic [3:0] OpNot = 4'd5;
  localparam logic [3:0] OpPsB = 4'd6;
  localparam logic [3:0] OpPsA = 4'd7;
  localparam logic [3:0] OpShl = 4'd8;
  localparam logic [3:0] OpShr = 4'd9;
  localparam logic [3:0] OpSar = 4'd10;
  localparam logic [3:0] OpRol = 4'd11;
  localparam logic [3:0] OpMul = 4'd12;

  localparam logic [SHW:0] MulCnt = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] One    = (SHW+1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;
  logic             pcy_q;
  logic             pov_q;
  logic             cy_q;
  logic [SHW:0]     cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] hi_q;
  logic [4:0]       flg_q;

  logic             unused_flg;
  assign unused_flg = ^{in_flg[4], in_flg[2:1]};

  // accept-time classification
  logic         is_sh;
  logic         is_mul;
  logic [SHW:0] cnt_d;

  always_comb begin
    is_sh  = (opcode >= OpShl) && (opcode <= OpRol);
`ifdef ALU_MUL_EN
    is_mul = (opcode == OpMul);
`else
    is_mul = 1'b0;
`endif
    cnt_d = '0;
    unique case (1'b1)
      is_sh:   cnt_d = {1'b0, arg2[SHW-1:0]};
      is_mul:  cnt_d = MulCnt;
      default: cnt_d = '0;
    endcase
  end

  // one shift/rotate step on the working register
  logic [WIDTH-1:0] sh_d;
  logic             sho_d;

  always_comb begin
    sh_d  = a_q;
    sho_d = cy_q;
    case (op_q)
      OpShl: begin
        sh_d  = {a_q[WIDTH-2:0], 1'b0};
        sho_d = a_q[WIDTH-1];
      end
      OpShr: begin
        sh_d  = {1'b0, a_q[WIDTH-1:1]};
        sho_d = a_q[0];
      end
      OpSar: begin
        sh_d  = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
        sho_d = a_q[0];
      end
      OpRol: begin
        sh_d  = {a_q[WIDTH-2:0], a_q[WIDTH-1]};
        sho_d = a_q[WIDTH-1];
      end
      default: begin
        sh_d  = a_q;
        sho_d = cy_q;
      end
    endcase
  end

`ifdef ALU_MUL_EN
  // shift-add step: {hi,b} holds the partial product, b's low bit
  // is the current multiplier bit
  logic [WIDTH:0] macc;
  always_comb begin
    macc = {1'b0, hi_q};
    if (b_q[0]) macc = {1'b0, hi_q} + {1'b0, a_q};
  end
`endif

  // final result and flags, evaluated on the edge that raises done
  logic [WIDTH:0]   tmp;
  logic [WIDTH-1:0] fr;
  logic [WIDTH-1:0] fh;
  logic             fcy;
  logic             fov;
  logic [4:0]       ff;

  always_comb begin
    tmp = '0;
    fr  = a_q;
    fh  = '0;
    fcy = 1'b0;
    fov = 1'b0;
    case (op_q)
      OpAdd: begin
        tmp = {1'b0, a_q} + {1'b0, b_q}
            + {{WIDTH{1'b0}}, cin_q};
        fr  = tmp[WIDTH-1:0];
        fcy = tmp[WIDTH];
        fov = (a_q[WIDTH-1] == b_q[WIDTH-1])
           && (fr[WIDTH-1] != a_q[WIDTH-1]);
      end
      OpSub: begin
        tmp = {1'b0, a_q} - {1'b0, b_q}
            - {{WIDTH{1'b0}}, cin_q};
        fr  = tmp[WIDTH-1:0];
        fcy = tmp[WIDTH];
        fov = (a_q[WIDTH-1] != b_q[WIDTH-1])
           && (fr[WIDTH-1] != a_q[WIDTH-1]);
      end
      OpAnd: fr = a_q & b_q;
      OpOr:  fr = a_q | b_q;
      OpXor: fr = a_q ^ b_q;
      OpNot: fr = ~a_q;
      OpPsB: begin
        fr  = b_q;
        fcy = pcy_q;
        fov = pov_q;
      end
      OpPsA: begin
        fr  = a_q;
        fcy = pcy_q;
        fov = pov_q;
      end
      OpShl, OpShr, OpSar, OpRol: begin
        fr  = a_q;
        fcy = cy_q;
      end
`ifdef ALU_MUL_EN
      OpMul: begin
        fr  = b_q;
        fh  = hi_q;
        fcy = |hi_q;
      end
`endif
      default: fr = a_q;
    endcase
    ff = {~|fr, fcy, fr[WIDTH-1], ^fr, fov};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      pcy_q   <= 1'b0;
      pov_q   <= 1'b0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      hi_q    <= '0;
      flg_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            op_q    <= opcode;
            a_q     <= arg1;
            b_q     <= arg2;
            cin_q   <= in_flg[3];
            pcy_q   <= in_flg[3];
            pov_q   <= in_flg[0];
            cy_q    <= in_flg[3];
            cnt_q   <= cnt_d;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (cnt_q == '0) begin
            res_q   <= fr;
            hi_q    <= fh;
            flg_q   <= ff;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - One;
`ifdef ALU_MUL_EN
            if (op_q == OpMul) begin
              hi_q <= macc[WIDTH:1];
              b_q  <= {macc[0], b_q[WIDTH-1:1]};
            end else begin
              a_q  <= sh_d;
              cy_q <= sho_d;
            end
`else
            a_q  <= sh_d;
            cy_q <= sho_d;
`endif
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign res     = res_q;
  assign res_hi  = hi_q;
  assign out_flg = flg_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH=16).
// Expectations follow the build's ALU_MUL_EN setting.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  opcode;
  logic [15:0] arg1;
  logic [15:0] arg2;
  logic [4:0]  in_flg;
  logic        busy;
  logic        done;
  logic [15:0] res;
  logic [15:0] res_hi;
  logic [4:0]  out_flg;

  int checks = 0;
  int errors = 0;
  int edges;
  int dpulses;

  alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .opcode(opcode), .arg1(arg1), .arg2(arg2),
    .in_flg(in_flg), .busy(busy), .done(done),
    .res(res), .res_hi(res_hi), .out_flg(out_flg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    @(negedge clk);
    while (busy && g < 200) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic issue(input logic [3:0] op,
                       input logic [15:0] a,
                       input logic [15:0] b,
                       input logic [4:0] f);
    wait_idle();
    opcode = op; arg1 = a; arg2 = b; in_flg = f;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic op(input string tag,
                    input logic [3:0] o,
                    input logic [15:0] a,
                    input logic [15:0] b,
                    input logic [4:0] f,
                    input int en,
                    input logic [15:0] er,
                    input logic [15:0] eh,
                    input logic [4:0] ef);
    int n;
    issue(o, a, b, f);
    wait_done(n);
    chk({tag, "_edge"}, n, en);
    chk({tag, "_res"}, res, er);
    chk({tag, "_hi"}, res_hi, eh);
    chk({tag, "_flg"}, out_flg, ef);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; opcode = '0;
    arg1 = '0; arg2 = '0; in_flg = '0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", res, 0);
    chk("rst_flg", out_flg, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    op("add_ov", 4'd0, 16'h7FFF, 16'h0001, 5'b00000,
       1, 16'h8000, 16'h0, 5'b00111);

    // reset in the middle of a MUL
    issue(4'd12, 16'h00FF, 16'h00FF, 5'b00000);
`ifdef ALU_MUL_EN
    repeat (5) @(posedge clk);
    #2;
`endif
    chk("mrst_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_res", res, 0);
    chk("mrst_hi", res_hi, 0);
    chk("mrst_flg", out_flg, 0);
    @(negedge clk);
    rst_n = 1'b1;
    op("add_post", 4'd0, 16'hFFFF, 16'h0001, 5'b00000,
       1, 16'h0000, 16'h0, 5'b11000);

    op("sub_b0", 4'd1, 16'h0000, 16'h0001, 5'b00000,
       1, 16'hFFFF, 16'h0, 5'b01100);
    op("sub_b1", 4'd1, 16'h0000, 16'h0001, 5'b01000,
       1, 16'hFFFE, 16'h0, 5'b01110);

    op("shr1", 4'd9, 16'h8001, 16'h0001, 5'b00000,
       2, 16'h4000, 16'h0, 5'b01010);
    op("sar4", 4'd10, 16'h8000, 16'h0004, 5'b01000,
       5, 16'hF800, 16'h0, 5'b00110);
    op("shr0", 4'd9, 16'hA5A5, 16'h0000, 5'b01000,
       1, 16'hA5A5, 16'h0, 5'b01100);
    op("rol1", 4'd11, 16'h8001, 16'h0001, 5'b00000,
       2, 16'h0003, 16'h0, 5'b01000);

    op("and", 4'd2, 16'hF0F0, 16'h3C3C, 5'b11111,
       1, 16'h3030, 16'h0, 5'b00000);
    op("or", 4'd3, 16'h0000, 16'h0000, 5'b01001,
       1, 16'h0000, 16'h0, 5'b10000);
    op("xor", 4'd4, 16'hF0F0, 16'h3C3C, 5'b00000,
       1, 16'hCCCC, 16'h0, 5'b00100);
    op("not", 4'd5, 16'h0000, 16'h1234, 5'b00000,
       1, 16'hFFFF, 16'h0, 5'b00100);
    op("passb", 4'd6, 16'hFFFF, 16'h0001, 5'b01001,
       1, 16'h0001, 16'h0, 5'b01011);
    op("passa", 4'd7, 16'h8000, 16'h0001, 5'b00000,
       1, 16'h8000, 16'h0, 5'b00110);
    op("rsvd", 4'd14, 16'h0007, 16'h0001, 5'b01001,
       1, 16'h0007, 16'h0, 5'b00010);

`ifdef ALU_MUL_EN
    op("mul", 4'd12, 16'h0100, 16'h0100, 5'b00000,
       17, 16'h0000, 16'h0001, 5'b11000);
`else
    op("mul", 4'd12, 16'h0100, 16'h0100, 5'b00000,
       1, 16'h0100, 16'h0000, 5'b00010);
`endif

    // handshake: start held high, inputs change while busy
    wait_idle();
    opcode = 4'd8; arg1 = 16'h0001; arg2 = 16'h0003;
    in_flg = 5'b00000;
    start = 1'b1;
    @(posedge clk); #1;
    opcode = 4'd0; arg1 = 16'hFFFF; arg2 = 16'h0000;
    dpulses = 0;
    wait_done(edges);
    chk("hs_edge", edges, 4);
    chk("hs_res", res, 16'h0008);
    chk("hs_flg", out_flg, 5'b00010);
    chk("hs_busy_done", busy, 1);
    @(posedge clk); #1;
    chk("hs_done_fall", done, 0);
    chk("hs_idle", busy, 0);
    @(posedge clk); #1;
    chk("hs_accept2", busy, 1);
    chk("hs_accept2_nd", done, 0);
    start = 1'b0;
    @(posedge clk); #1;
    chk("hs2_done", done, 1);
    chk("hs2_res", res, 16'hFFFF);
    chk("hs2_flg", out_flg, 5'b00100);
    repeat (3) begin
      @(posedge clk); #1;
      if (done) dpulses++;
    end
    chk("hs2_single", dpulses, 0);
    chk("hs2_hold", res, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
